// File: rtl/vx_tex_csr_bank.sv
// Texture CSR bank: per-stage shadow state written over CSR, atomically committed to active
// state once the stage drains. Define VX_TEX_CSR_PERF_EN to add stall performance counters.
`ifndef CSR_ADDR_BITS
`define CSR_ADDR_BITS 12
`endif
`ifndef UUID_BITS
`define UUID_BITS 44
`endif

module vx_tex_csr_bank #(
  parameter int NUM_STAGES = 4,
  parameter logic [`CSR_ADDR_BITS-1:0] CSR_BASE = 12'h7C0,
  parameter int CNT_W = 4,
  localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       write_enable,
  input  logic [`CSR_ADDR_BITS-1:0]  write_addr,
  input  logic [31:0]                write_data,
  input  logic [`UUID_BITS-1:0]      write_uuid,
  input  logic                       tex_req_valid,
  input  logic [SW-1:0]              tex_req_stage,
  output logic                       tex_req_ready,
  input  logic                       tex_rsp_valid,
  input  logic [SW-1:0]              tex_rsp_stage,
  output logic [NUM_STAGES*32-1:0]   stage_addr,
  output logic [NUM_STAGES*8-1:0]    stage_logdim,
  output logic [NUM_STAGES*3-1:0]    stage_format,
  output logic [NUM_STAGES*4-1:0]    stage_wrap,
  output logic [NUM_STAGES-1:0]      stage_filter,
  output logic [NUM_STAGES-1:0]      commit_pending,
  output logic [`UUID_BITS-1:0]      commit_uuid
`ifdef VX_TEX_CSR_PERF_EN
  ,
  output logic [31:0]                perf_commit_stalls,
  output logic [31:0]                perf_req_stalls
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [2:0]              r_select;
  logic [31:0]             r_shAddr   [NUM_STAGES];
  logic [7:0]              r_shLogdim [NUM_STAGES];
  logic [2:0]              r_shFormat [NUM_STAGES];
  logic [3:0]              r_shWrap   [NUM_STAGES];
  logic                    r_shFilter [NUM_STAGES];
  logic [31:0]             r_acAddr   [NUM_STAGES];
  logic [7:0]              r_acLogdim [NUM_STAGES];
  logic [2:0]              r_acFormat [NUM_STAGES];
  logic [3:0]              r_acWrap   [NUM_STAGES];
  logic                    r_acFilter [NUM_STAGES];
  logic [CNT_W-1:0]        r_inflight [NUM_STAGES];
  logic [NUM_STAGES-1:0]   r_pending;
  logic [`UUID_BITS-1:0]   r_commitUuid;

  logic [`CSR_ADDR_BITS-1:0] w_delta;
  logic                      w_inBank;
  logic [2:0]                w_offset;
  logic                      w_selValid;
  logic                      w_fieldWr;
  logic [NUM_STAGES-1:0]     w_commitSet;
  logic [NUM_STAGES-1:0]     w_commitNow;
  logic [NUM_STAGES-1:0]     w_stageReady;
  logic [NUM_STAGES-1:0]     w_fire;
  logic [NUM_STAGES-1:0]     w_rsp;

  // Unsigned wraparound of the subtraction makes one compare cover both bank bounds.
  assign w_delta     = write_addr - CSR_BASE;
  assign w_inBank    = write_enable && (w_delta < `CSR_ADDR_BITS'(8));
  assign w_offset    = w_delta[2:0];
  assign w_selValid  = ({1'b0, r_select} < 4'(NUM_STAGES));
  assign w_fieldWr   = w_inBank && w_selValid && (w_offset >= 3'd1) && (w_offset <= 3'd5);
  assign w_commitSet = (w_inBank && (w_offset == 3'd7)) ? write_data[NUM_STAGES-1:0] : '0;

  always_comb begin
    w_stageReady = '0;
    w_commitNow  = '0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      w_stageReady[s] = !r_pending[s] && (r_inflight[s] != CNT_MAX);
      w_commitNow[s]  = r_pending[s] && (r_inflight[s] == '0);
    end
  end

  // Stage match by loop keeps out-of-range stage numbers from indexing past the arrays.
  always_comb begin
    tex_req_ready = 1'b0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      if (tex_req_stage == SW'(s)) tex_req_ready = w_stageReady[s];
    end
  end

  always_comb begin
    w_fire = '0;
    w_rsp  = '0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      w_fire[s] = tex_req_valid && tex_req_ready && (tex_req_stage == SW'(s));
      w_rsp[s]  = tex_rsp_valid && (tex_rsp_stage == SW'(s));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_select     <= '0;
      r_commitUuid <= '0;
      for (int s = 0; s < NUM_STAGES; s++) begin
        r_shAddr[s]   <= '0;
        r_shLogdim[s] <= '0;
        r_shFormat[s] <= '0;
        r_shWrap[s]   <= '0;
        r_shFilter[s] <= 1'b0;
      end
    end else begin
      if (w_inBank && (w_offset == 3'd0)) r_select <= write_data[2:0];
      if (w_inBank && (w_offset == 3'd7)) r_commitUuid <= write_uuid;
      for (int s = 0; s < NUM_STAGES; s++) begin
        if (w_fieldWr && (r_select == 3'(s))) begin
          case (w_offset)
            3'd1:    r_shAddr[s]   <= write_data;
            3'd2:    r_shLogdim[s] <= write_data[7:0];
            3'd3:    r_shFormat[s] <= write_data[2:0];
            3'd4:    r_shWrap[s]   <= write_data[3:0];
            3'd5:    r_shFilter[s] <= write_data[0];
            default: ;
          endcase
        end
      end
    end
  end

  // A COMMIT write in the same cycle as a commit edge re-arms pending (set beats clear).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
      for (int s = 0; s < NUM_STAGES; s++) begin
        r_inflight[s] <= '0;
        r_acAddr[s]   <= '0;
        r_acLogdim[s] <= '0;
        r_acFormat[s] <= '0;
        r_acWrap[s]   <= '0;
        r_acFilter[s] <= 1'b0;
      end
    end else begin
      for (int s = 0; s < NUM_STAGES; s++) begin
        r_pending[s] <= (r_pending[s] && !w_commitNow[s]) || w_commitSet[s];
        if (w_commitNow[s]) begin
          r_acAddr[s]   <= r_shAddr[s];
          r_acLogdim[s] <= r_shLogdim[s];
          r_acFormat[s] <= r_shFormat[s];
          r_acWrap[s]   <= r_shWrap[s];
          r_acFilter[s] <= r_shFilter[s];
        end
        if (w_fire[s] && !w_rsp[s]) begin
          r_inflight[s] <= r_inflight[s] + CNT_W'(1);
        end else if (w_rsp[s] && !w_fire[s] && (r_inflight[s] != '0)) begin
          r_inflight[s] <= r_inflight[s] - CNT_W'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    assign stage_addr[g*32 +: 32]  = r_acAddr[g];
    assign stage_logdim[g*8 +: 8]  = r_acLogdim[g];
    assign stage_format[g*3 +: 3]  = r_acFormat[g];
    assign stage_wrap[g*4 +: 4]    = r_acWrap[g];
    assign stage_filter[g]         = r_acFilter[g];

    a_rspUnderflow : assert property (@(posedge clk) disable iff (!reset_n)
      !(w_rsp[g] && !w_fire[g] && (r_inflight[g] == '0)));
  end

  assign commit_pending = r_pending;
  assign commit_uuid    = r_commitUuid;

`ifdef VX_TEX_CSR_PERF_EN
  logic [31:0] r_perfCommit;
  logic [31:0] r_perfReq;
  logic        w_drainStall;

  // A pending stage that cannot commit yet is exactly one with a nonzero counter.
  assign w_drainStall = |(r_pending & ~w_commitNow);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perfCommit <= '0;
      r_perfReq    <= '0;
    end else begin
      if (w_drainStall) r_perfCommit <= r_perfCommit + 32'd1;
      if (tex_req_valid && !tex_req_ready) r_perfReq <= r_perfReq + 32'd1;
    end
  end

  assign perf_commit_stalls = r_perfCommit;
  assign perf_req_stalls    = r_perfReq;
`endif

endmodule

// File: tb/tb_vx_tex_csr_bank.sv
// Randomized self-checking bench for vx_tex_csr_bank against a per-stage behavioural model.
`ifndef CSR_ADDR_BITS
`define CSR_ADDR_BITS 12
`endif
`ifndef UUID_BITS
`define UUID_BITS 44
`endif

module tb_vx_tex_csr_bank;
  localparam int NS     = 4;
  localparam int CW     = 2;
  localparam int MAXCNT = 3;
  localparam int SW     = 2;
  localparam int UB     = `UUID_BITS;
  localparam int AB     = `CSR_ADDR_BITS;
  localparam logic [AB-1:0] BASE = 12'h7C0;

  logic              clk;
  logic              reset_n;
  logic              writeEnable;
  logic [AB-1:0]     writeAddr;
  logic [31:0]       writeData;
  logic [UB-1:0]     writeUuid;
  logic              texReqValid;
  logic [SW-1:0]     texReqStage;
  logic              texReqReady;
  logic              texRspValid;
  logic [SW-1:0]     texRspStage;
  logic [NS*32-1:0]  stageAddr;
  logic [NS*8-1:0]   stageLogdim;
  logic [NS*3-1:0]   stageFormat;
  logic [NS*4-1:0]   stageWrap;
  logic [NS-1:0]     stageFilter;
  logic [NS-1:0]     commitPending;
  logic [UB-1:0]     commitUuid;
`ifdef VX_TEX_CSR_PERF_EN
  logic [31:0]       perfCommitStalls;
  logic [31:0]       perfReqStalls;
`endif

  vx_tex_csr_bank #(.NUM_STAGES(NS), .CSR_BASE(BASE), .CNT_W(CW)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .write_enable(writeEnable),
    .write_addr(writeAddr),
    .write_data(writeData),
    .write_uuid(writeUuid),
    .tex_req_valid(texReqValid),
    .tex_req_stage(texReqStage),
    .tex_req_ready(texReqReady),
    .tex_rsp_valid(texRspValid),
    .tex_rsp_stage(texRspStage),
    .stage_addr(stageAddr),
    .stage_logdim(stageLogdim),
    .stage_format(stageFormat),
    .stage_wrap(stageWrap),
    .stage_filter(stageFilter),
    .commit_pending(commitPending),
    .commit_uuid(commitUuid)
`ifdef VX_TEX_CSR_PERF_EN
    ,
    .perf_commit_stalls(perfCommitStalls),
    .perf_req_stalls(perfReqStalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the architectural state of each stage as plain arrays.
  logic [31:0]   mShAddr [NS];
  logic [7:0]    mShLog  [NS];
  logic [2:0]    mShFmt  [NS];
  logic [3:0]    mShWrap [NS];
  logic          mShFilt [NS];
  logic [31:0]   mAcAddr [NS];
  logic [7:0]    mAcLog  [NS];
  logic [2:0]    mAcFmt  [NS];
  logic [3:0]    mAcWrap [NS];
  logic          mAcFilt [NS];
  int            mCnt    [NS];
  logic [NS-1:0] mPend;
  int            mSel;
  logic [UB-1:0] mUuid;
  logic [31:0]   mPerfC;
  logic [31:0]   mPerfR;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int s = 0; s < NS; s++) begin
      mShAddr[s] = '0; mShLog[s] = '0; mShFmt[s] = '0; mShWrap[s] = '0; mShFilt[s] = 1'b0;
      mAcAddr[s] = '0; mAcLog[s] = '0; mAcFmt[s] = '0; mAcWrap[s] = '0; mAcFilt[s] = 1'b0;
      mCnt[s] = 0;
    end
    mPend = '0; mSel = 0; mUuid = '0; mPerfC = '0; mPerfR = '0;
  endtask

  task automatic checkState(input string tag);
    logic [NS*32-1:0] eAddr;
    logic [NS*8-1:0]  eLog;
    logic [NS*3-1:0]  eFmt;
    logic [NS*4-1:0]  eWrap;
    logic [NS-1:0]    eFilt;
    for (int s = 0; s < NS; s++) begin
      eAddr[s*32 +: 32] = mAcAddr[s];
      eLog[s*8 +: 8]    = mAcLog[s];
      eFmt[s*3 +: 3]    = mAcFmt[s];
      eWrap[s*4 +: 4]   = mAcWrap[s];
      eFilt[s]          = mAcFilt[s];
    end
    checkOutput({tag, ".addr"}, 128'(stageAddr), 128'(eAddr));
    checkOutput({tag, ".logdim"}, 128'(stageLogdim), 128'(eLog));
    checkOutput({tag, ".format"}, 128'(stageFormat), 128'(eFmt));
    checkOutput({tag, ".wrap"}, 128'(stageWrap), 128'(eWrap));
    checkOutput({tag, ".filter"}, 128'(stageFilter), 128'(eFilt));
    checkOutput({tag, ".pending"}, 128'(commitPending), 128'(mPend));
    checkOutput({tag, ".uuid"}, 128'(commitUuid), 128'(mUuid));
`ifdef VX_TEX_CSR_PERF_EN
    checkOutput({tag, ".perfCommit"}, 128'(perfCommitStalls), 128'(mPerfC));
    checkOutput({tag, ".perfReq"}, 128'(perfReqStalls), 128'(mPerfR));
`endif
  endtask

  // Drives one cycle from a negedge, checks the combinational ready, advances the model
  // over the edge and checks the registered outputs.
  task automatic applyStimulus(input logic we, input logic [AB-1:0] addr, input logic [31:0] data,
                               input logic [UB-1:0] uuid, input logic rv, input int rs,
                               input logic pv, input int ps);
    logic          expReady;
    logic [NS-1:0] canCommit;
    logic [AB-1:0] delta;
    logic          anyStall;
    writeEnable = we; writeAddr = addr; writeData = data; writeUuid = uuid;
    texReqValid = rv; texReqStage = SW'(rs); texRspValid = pv; texRspStage = SW'(ps);
    #1;
    expReady = (rs < NS) && !mPend[rs] && (mCnt[rs] != MAXCNT);
    checkOutput("ready", 128'(texReqReady), 128'(expReady));

    anyStall = 1'b0;
    for (int s = 0; s < NS; s++) begin
      canCommit[s] = mPend[s] && (mCnt[s] == 0);
      if (mPend[s] && (mCnt[s] != 0)) anyStall = 1'b1;
    end
    if (anyStall) mPerfC = mPerfC + 32'd1;
    if (rv && !expReady) mPerfR = mPerfR + 32'd1;

    for (int s = 0; s < NS; s++) begin
      logic fire, rsp;
      if (canCommit[s]) begin
        mAcAddr[s] = mShAddr[s]; mAcLog[s] = mShLog[s]; mAcFmt[s] = mShFmt[s];
        mAcWrap[s] = mShWrap[s]; mAcFilt[s] = mShFilt[s];
        mPend[s] = 1'b0;
      end
      fire = rv && expReady && (rs == s);
      rsp  = pv && (ps == s);
      if (fire && !rsp) mCnt[s]++;
      else if (rsp && !fire && mCnt[s] > 0) mCnt[s]--;
    end

    delta = addr - BASE;
    if (we && delta < AB'(8)) begin
      case (int'(delta))
        0: mSel = int'(data[2:0]);
        1: if (mSel < NS) mShAddr[mSel] = data;
        2: if (mSel < NS) mShLog[mSel] = data[7:0];
        3: if (mSel < NS) mShFmt[mSel] = data[2:0];
        4: if (mSel < NS) mShWrap[mSel] = data[3:0];
        5: if (mSel < NS) mShFilt[mSel] = data[0];
        7: begin mPend = mPend | data[NS-1:0]; mUuid = uuid; end
        default: ;
      endcase
    end

    @(posedge clk);
    #1;
    checkState("cycle");
    @(negedge clk);
  endtask

  task automatic wr(input int off, input logic [31:0] data);
    applyStimulus(1'b1, BASE + AB'(off), data, UB'({$urandom(), $urandom()}), 1'b0, 0, 1'b0, 0);
  endtask

  task automatic req(input int stage);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, stage, 1'b0, 0);
  endtask

  task automatic rsp(input int stage);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 0, 1'b1, stage);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, '0, 1'b0, 0, 1'b0, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    writeEnable = 1'b0; writeAddr = '0; writeData = '0; writeUuid = '0;
    texReqValid = 1'b0; texReqStage = '0; texRspValid = 1'b0; texRspStage = '0;
    modelReset();
    #1;
    checkState("reset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    for (int s = 0; s < NS; s++) applyStimulus(1'b0, '0, '0, '0, 1'b0, s, 1'b0, 0);

    // Basic commit on an idle stage.
    wr(0, 32'd2);
    wr(1, 32'hDEAD0000);
    wr(7, 32'h4);
    idle(2);

    // Commit held off until stage 1 drains.
    wr(0, 32'd1);
    wr(1, 32'hCAFE0001);
    for (int i = 0; i < 3; i++) req(1);
    wr(7, 32'h2);
    req(1);
    for (int i = 0; i < 3; i++) rsp(1);
    idle(2);

    // Counter saturation on stage 0.
    for (int i = 0; i < 4; i++) req(0);
    rsp(0);
    req(0);
    for (int i = 0; i < 3; i++) rsp(0);

    // COMMIT write landing on a commit edge re-arms pending.
    wr(0, 32'd0);
    wr(1, 32'hAAAA0000);
    req(0);
    wr(7, 32'h1);
    wr(1, 32'hBBBB0000);
    rsp(0);
    wr(7, 32'h1);
    wr(1, 32'hCCCC0000);
    idle(2);

    // Out-of-range select drops field writes; reserved and out-of-bank writes ignored.
    wr(0, 32'd5);
    wr(1, 32'h1234);
    wr(6, 32'hFFFF_FFFF);
    applyStimulus(1'b1, BASE - AB'(1), 32'hFF, '0, 1'b0, 0, 1'b0, 0);
    applyStimulus(1'b1, BASE + AB'(8), 32'hFF, '0, 1'b0, 0, 1'b0, 0);
    wr(7, 32'hF);
    idle(2);

    // Asynchronous reset in the middle of a drain.
    wr(0, 32'd1);
    wr(1, 32'h5555_0000);
    req(0);
    req(1);
    wr(7, 32'h3);
    #2;
    reset_n = 1'b0;
    modelReset();
    #1;
    checkState("asyncReset");
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);

    // Randomized traffic.
    for (int n = 0; n < 500; n++) begin
      logic          we, rv, pv;
      logic [AB-1:0] addr;
      logic [31:0]   data;
      int            rs, ps, off, pick;
      we  = ($urandom_range(0, 99) < 40);
      off = $urandom_range(0, 7);
      pick = $urandom_range(0, 9);
      if (pick == 0)      addr = BASE - AB'(1);
      else if (pick == 1) addr = BASE + AB'(8);
      else if (pick == 2) addr = AB'($urandom());
      else                addr = BASE + AB'(off);
      data = $urandom();
      if (addr == BASE) data = 32'($urandom_range(0, 5));
      if (addr == BASE + AB'(7) && $urandom_range(0, 3) == 0) data = '0;
      rv = $urandom_range(0, 1) == 1;
      rs = $urandom_range(0, NS - 1);
      ps = $urandom_range(0, NS - 1);
      pv = ($urandom_range(0, 99) < 45) && (mCnt[ps] > 0);
      applyStimulus(we, addr, data, UB'({$urandom(), $urandom()}), rv, rs, pv, ps);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vx_tex_csr_bank.md
Name: vx_tex_csr_bank

Overview:
- Parametrised texture CSR bank, successor to the single-channel texture CSR write interface.
- Decodes CSR writes (enable/addr/data/uuid) into per-stage shadow state for NUM_STAGES texture stages.
- Atomically commits shadow to active state per stage, only once that stage has no texture requests in flight.
- Sits between the CSR unit and the texture unit; drives the texture unit's stage state and gates its request acceptance.

Parameters:
- NUM_STAGES, 4, number of texture stages (1..8).
- CSR_BASE, 12'h7C0, first CSR address of the bank; the bank occupies CSR_BASE..CSR_BASE+7.
- CNT_W, 4, in-flight counter width per stage; max outstanding = 2^CNT_W-1.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- write_enable  in  1  CSR write strobe
- write_addr  in  `CSR_ADDR_BITS  CSR address
- write_data  in  32  CSR write data
- write_uuid  in  `UUID_BITS  instruction uuid of the write
- tex_req_valid  in  1  texture request presented
- tex_req_stage  in  $clog2(NUM_STAGES) (min 1)  stage of the request
- tex_req_ready  out  1  request accepted this cycle
- tex_rsp_valid  in  1  texture response retired (always accepted)
- tex_rsp_stage  in  $clog2(NUM_STAGES) (min 1)  stage of the response
- stage_addr  out  NUM_STAGES*32  active base address per stage
- stage_logdim  out  NUM_STAGES*8  active {log2 height[7:4], log2 width[3:0]}
- stage_format  out  NUM_STAGES*3  active texel format
- stage_wrap  out  NUM_STAGES*4  active {wrap_v[3:2], wrap_u[1:0]}
- stage_filter  out  NUM_STAGES  active filter (0 point, 1 bilinear)
- commit_pending  out  NUM_STAGES  commit requested, not yet applied
- commit_uuid  out  `UUID_BITS  uuid of the most recent commit-register write

Behaviour:
- Interface decision: single clock clk; reset_n is asynchronous, active-low.
- CSR map, offsets from CSR_BASE:
  - +0 SELECT: data[2:0] selects the stage.
  - +1 ADDR, +2 LOGDIM[7:0], +3 FORMAT[2:0], +4 WRAP[3:0], +5 FILTER[0]: written into the shadow copy of the selected stage.
  - +6 reserved, ignored.
  - +7 COMMIT: data[NUM_STAGES-1:0] is a commit mask.
  - Addresses outside the bank are ignored.
  - SELECT >= NUM_STAGES: later field writes are dropped; the select register keeps the written value.
- A field write updates the shadow copy at the next edge. Active outputs do not change on a field write.
- COMMIT write: pending <= pending | mask (bits >= NUM_STAGES ignored); commit_uuid <= write_uuid. A zero mask updates only commit_uuid.
- Per-stage in-flight counter:
  - +1 on request fire (tex_req_valid && tex_req_ready).
  - -1 on tex_rsp_valid for that stage.
  - Fire and response on the same stage in the same cycle leave the counter unchanged.
  - A response on a zero counter is a protocol error; the counter holds at 0 (assertion in simulation).
- tex_req_ready = !pending[tex_req_stage] && inflight[tex_req_stage] != max && tex_req_stage < NUM_STAGES. Combinational.
- Commit rule: at an edge where pending[s] && inflight[s]==0, active[s] <= shadow[s] and pending[s] <= 0.
  - Earliest case: the commit write is registered at edge N and active is updated at edge N+1.
- A field write to a pending stage still updates shadow; the committed value is the shadow at the commit edge.
- A COMMIT write in the same cycle as a commit edge for that stage: the clear loses to the set, so pending stays 1 and a second commit follows.
- Reset: all shadow, active, select, counters, pending, and commit_uuid are 0. tex_req_ready therefore follows only tex_req_valid-independent terms and is 1 for valid stages.
- Reset mid-drain discards pending commits and counters.

Optional Feature:
- Macro: VX_TEX_CSR_PERF_EN.
- Defined:
  - Adds output perf_commit_stalls[31:0]: increments each cycle any pending bit is set and the stage counter is nonzero; wraps at 2^32.
  - Adds output perf_req_stalls[31:0]: increments each cycle tex_req_valid && !tex_req_ready.
  - Both counters reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then SELECT=2, ADDR=0xDEAD0000, COMMIT=0x4 -> stage_addr[2] = 0xDEAD0000 one edge after the commit write; other stages remain 0.
- Stage 1: 3 requests fire, COMMIT=0x2 -> tex_req_ready=0 for stage 1. After 3 responses, active updates at the edge where the counter is 0 and commit_pending[1] falls.
- CNT_W=2, stage 0: 3 fires without responses -> tex_req_ready=0. One response -> ready=1.
- COMMIT write coinciding with a commit edge on stage 0 -> commit_pending[0] stays 1, and a second commit lands the newest shadow.
- SELECT=5 with NUM_STAGES=4, then ADDR=0x1234 -> no shadow change; after COMMIT=0xF, all stages retain their prior values.
- Assert reset_n low mid-drain with pending=0x3 -> all outputs 0 immediately (asynchronous); after release, commit_pending=0.
